// File: rtl/tile_scheduler.sv
// Top-level sequencer for the systolic array.
// Walks (filter tile, pixel tile) pairs with the pixel tile as the inner loop.
// For each tile it fires load pulses, waits for both address controllers,
// runs the skewed compute window, then drains rows to the output buffer.
// Note: rst_n is a synchronous, active-HIGH reset despite its name
// (the port name is fixed by the surrounding integration).
module tile_scheduler #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned KERNEL_SIZE   = 1,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned NO_FILTER     = 19,
  parameter int unsigned NO_PIXEL      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wgt_ready,
  input  logic       ifm_ready,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       wgt_load,
  output logic       ifm_load,
  output logic [4:0] wgt_size,
  output logic [4:0] ifm_size,
  output logic       acc_clr,
  output logic       compute_en,
  output logic       drain_en,
  output logic [3:0] f_tile,
  output logic [3:0] p_tile
);

  localparam int unsigned K        = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int unsigned NF       = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned NP       = (NO_PIXEL + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned COMP     = K + 2 * SYSTOLIC_SIZE - 2;
  localparam int unsigned CW       = $clog2(COMP + 1);
  localparam int unsigned LAST_WGT = NO_FILTER - (NF - 1) * SYSTOLIC_SIZE;
  localparam int unsigned LAST_IFM = NO_PIXEL - (NP - 1) * SYSTOLIC_SIZE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_LD = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [3:0]    f_tile_d;
  logic [3:0]    p_tile_d;
  logic [4:0]    wgt_size_d;
  logic [4:0]    ifm_size_d;
  logic          wgt_flag;
  logic          wgt_flag_d;
  logic          ifm_flag;
  logic          ifm_flag_d;
  logic [CW-1:0] comp_cnt;
  logic [CW-1:0] comp_cnt_d;
  logic [4:0]    row_cnt;
  logic [4:0]    row_cnt_d;
  logic          busy_d;
  logic          done_d;
  logic          load_d;
  logic          compute_en_d;

  // Next-state, counter, index and Moore output decode
  always_comb begin
    state_d    = state;
    f_tile_d   = f_tile;
    p_tile_d   = p_tile;
    wgt_size_d = wgt_size;
    ifm_size_d = ifm_size;
    wgt_flag_d = wgt_flag;
    ifm_flag_d = ifm_flag;
    comp_cnt_d = comp_cnt;
    row_cnt_d  = row_cnt;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          f_tile_d = 4'd0;
          p_tile_d = 4'd0;
        end
      end
      S_LOAD: begin
        // Readies seen during the load cycle belong to the previous tile
        wgt_flag_d = 1'b0;
        ifm_flag_d = 1'b0;
        comp_cnt_d = '0;
        row_cnt_d  = 5'd0;
        state_d    = S_WAIT_LD;
      end
      S_WAIT_LD: begin
        wgt_flag_d = wgt_flag | wgt_ready;
        ifm_flag_d = ifm_flag | ifm_ready;
        if (wgt_flag_d && ifm_flag_d) begin
          state_d    = S_COMPUTE;
          comp_cnt_d = '0;
        end
      end
      S_COMPUTE: begin
        if (comp_cnt == CW'(COMP - 1)) begin
          state_d   = S_DRAIN;
          row_cnt_d = 5'd0;
        end else begin
          comp_cnt_d = comp_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_cnt == wgt_size - 5'd1) begin
            state_d = S_NEXT;
          end else begin
            row_cnt_d = row_cnt + 5'd1;
          end
        end
      end
      S_NEXT: begin
        if (p_tile == 4'(NP - 1)) begin
          p_tile_d = 4'd0;
          if (f_tile == 4'(NF - 1)) begin
            f_tile_d = 4'd0;
            state_d  = S_DONE;
          end else begin
            f_tile_d = f_tile + 4'd1;
            state_d  = S_LOAD;
          end
        end else begin
          p_tile_d = p_tile + 4'd1;
          state_d  = S_LOAD;
        end
      end
      S_DONE: begin
        f_tile_d = 4'd0;
        p_tile_d = 4'd0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Tile sizes latch on entry to LOAD from the indices of the tile being loaded
    if (state_d == S_LOAD) begin
      wgt_size_d = (f_tile_d == 4'(NF - 1)) ? 5'(LAST_WGT) : 5'(SYSTOLIC_SIZE);
      ifm_size_d = (p_tile_d == 4'(NP - 1)) ? 5'(LAST_IFM) : 5'(SYSTOLIC_SIZE);
    end

    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    load_d       = (state_d == S_LOAD);
    compute_en_d = (state_d == S_COMPUTE);
  end

  // State, counters, flags and tile bookkeeping
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= S_IDLE;
      f_tile   <= 4'd0;
      p_tile   <= 4'd0;
      wgt_size <= 5'd0;
      ifm_size <= 5'd0;
      wgt_flag <= 1'b0;
      ifm_flag <= 1'b0;
      comp_cnt <= '0;
      row_cnt  <= 5'd0;
    end else begin
      state    <= state_d;
      f_tile   <= f_tile_d;
      p_tile   <= p_tile_d;
      wgt_size <= wgt_size_d;
      ifm_size <= ifm_size_d;
      wgt_flag <= wgt_flag_d;
      ifm_flag <= ifm_flag_d;
      comp_cnt <= comp_cnt_d;
      row_cnt  <= row_cnt_d;
    end
  end

  // Registered control outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      wgt_load   <= 1'b0;
      ifm_load   <= 1'b0;
      acc_clr    <= 1'b0;
      compute_en <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      wgt_load   <= load_d;
      ifm_load   <= load_d;
      acc_clr    <= load_d;
      compute_en <= compute_en_d;
    end
  end

  // Row shift-out is a same-cycle handshake with the output buffer
  assign drain_en = (state == S_DRAIN) && out_ready;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler with default parameters.
module tb_tile_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       wgt_ready;
  logic       ifm_ready;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       wgt_load;
  logic       ifm_load;
  logic [4:0] wgt_size;
  logic [4:0] ifm_size;
  logic       acc_clr;
  logic       compute_en;
  logic       drain_en;
  logic [3:0] f_tile;
  logic [3:0] p_tile;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Expected per-tile values for the default configuration, pixel-inner order
  int exp_w[4] = '{16, 16, 3, 3};
  int exp_i[4] = '{16, 4, 16, 4};
  int exp_f[4] = '{0, 0, 1, 1};
  int exp_p[4] = '{0, 1, 0, 1};

  tile_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wgt_ready  (wgt_ready),
    .ifm_ready  (ifm_ready),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .wgt_load   (wgt_load),
    .ifm_load   (ifm_load),
    .wgt_size   (wgt_size),
    .ifm_size   (ifm_size),
    .acc_clr    (acc_clr),
    .compute_en (compute_en),
    .drain_en   (drain_en),
    .f_tile     (f_tile),
    .p_tile     (p_tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses over the whole run
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; wgt_ready = 1'b0; ifm_ready = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    tick; tick;
    rst_n = 1'b0;
  endtask

  // From a LOAD cycle, run until the next LOAD (or DONE) with readies and out_ready held high
  task automatic finish_tile();
    int n = 0;
    wgt_ready = 1'b1; ifm_ready = 1'b1; out_ready = 1'b1;
    tick;
    while (wgt_load !== 1'b1 && done !== 1'b1 && n < 300) begin
      tick; n++;
    end
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL finish_tile: no next LOAD/DONE within %0d cycles", n);
    end
  endtask

  task automatic run_until_done();
    int n = 0;
    wgt_ready = 1'b1; ifm_ready = 1'b1; out_ready = 1'b1;
    while (done !== 1'b1 && n < 1000) begin
      tick; n++;
    end
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL run_until_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    start = 1'b1; wgt_ready = 1'b0; ifm_ready = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      outs = {busy, done, wgt_load, ifm_load, acc_clr, compute_en, drain_en,
              wgt_size, ifm_size, f_tile, p_tile};
      n_checks++;
      if (outs !== 25'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0", c, outs);
      end
    end
    rst_n = 1'b0;
    tick;
    n_checks++;
    if ({wgt_load, ifm_load, acc_clr, busy} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_release_load: got %b required 1111", {wgt_load, ifm_load, acc_clr, busy});
    end
    start = 1'b0;
  endtask

  task automatic test_full_layer();
    int cc;
    int dc;
    int d0;
    logic drain_in_comp;
    do_reset();
    d0 = done_cnt;
    out_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if ({wgt_load, ifm_load, acc_clr, busy} !== 4'b1111 || wgt_size !== 5'(exp_w[t]) ||
          ifm_size !== 5'(exp_i[t]) || f_tile !== 4'(exp_f[t]) || p_tile !== 4'(exp_p[t])) begin
        n_fail++;
        $display("FAIL full_load tile %0d: load=%b sizes=(%0d,%0d) idx=(%0d,%0d) required 1111 (%0d,%0d) (%0d,%0d)",
                 t, {wgt_load, ifm_load, acc_clr, busy}, wgt_size, ifm_size, f_tile, p_tile,
                 exp_w[t], exp_i[t], exp_f[t], exp_p[t]);
      end
      tick;
      wgt_ready = 1'b1; ifm_ready = 1'b1;
      tick;
      wgt_ready = 1'b0; ifm_ready = 1'b0;
      cc = 0; drain_in_comp = 1'b0;
      while (compute_en === 1'b1 && cc < 100) begin
        if (drain_en !== 1'b0 || wgt_load !== 1'b0) drain_in_comp = 1'b1;
        cc++; tick;
      end
      n_checks++;
      if (cc != 33 || drain_in_comp) begin
        n_fail++;
        $display("FAIL full_compute tile %0d: compute cycles %0d stray=%b, required 33 stray=0", t, cc, drain_in_comp);
      end
      dc = 0;
      while (drain_en === 1'b1 && dc < 100) begin
        dc++; tick;
      end
      n_checks++;
      if (dc != exp_w[t]) begin
        n_fail++;
        $display("FAIL full_drain tile %0d: drain cycles %0d required %0d", t, dc, exp_w[t]);
      end
      tick;
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || f_tile !== 4'd0 || p_tile !== 4'd0) begin
      n_fail++;
      $display("FAIL full_done: done=%b busy=%b idx=(%0d,%0d) required done=1 busy=0 (0,0)", done, busy, f_tile, p_tile);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wgt_load !== 1'b0 || (done_cnt - d0) != 1) begin
      n_fail++;
      $display("FAIL full_idle: done=%b busy=%b load=%b pulses=%0d required 0 0 0 1", done, busy, wgt_load, done_cnt - d0);
    end
  endtask

  task automatic test_ready_order();
    do_reset();
    out_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    // ifm_ready 2 cycles after load, wgt_ready 5 cycles after
    for (int c = 1; c <= 5; c++) begin
      tick;
      n_checks++;
      if (compute_en !== 1'b0) begin
        n_fail++;
        $display("FAIL order_stagger_wait cycle %0d: compute_en=%b required 0", c, compute_en);
      end
      ifm_ready = (c == 2);
      wgt_ready = (c == 5);
    end
    tick;
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n_checks++;
    if (compute_en !== 1'b1) begin
      n_fail++;
      $display("FAIL order_stagger_go: compute_en=%b required 1", compute_en);
    end
    finish_tile();
    // Both readies in the same cycle
    for (int c = 1; c <= 3; c++) begin
      tick;
      n_checks++;
      if (compute_en !== 1'b0) begin
        n_fail++;
        $display("FAIL order_same_wait cycle %0d: compute_en=%b required 0", c, compute_en);
      end
      wgt_ready = (c == 3);
      ifm_ready = (c == 3);
    end
    tick;
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n_checks++;
    if (compute_en !== 1'b1 || p_tile !== 4'd1) begin
      n_fail++;
      $display("FAIL order_same_go: compute_en=%b p_tile=%0d required 1 1", compute_en, p_tile);
    end
    finish_tile();
    // Readies only in the LOAD cycle must be ignored
    wgt_ready = 1'b1; ifm_ready = 1'b1;
    tick;
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (compute_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL order_loadcycle_stall cycle %0d: compute_en=%b busy=%b required 0 1", c, compute_en, busy);
      end
      tick;
    end
    wgt_ready = 1'b1; ifm_ready = 1'b1;
    tick;
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n_checks++;
    if (compute_en !== 1'b1 || f_tile !== 4'd1) begin
      n_fail++;
      $display("FAIL order_loadcycle_go: compute_en=%b f_tile=%0d required 1 1", compute_en, f_tile);
    end
    finish_tile();
    run_until_done();
    tick;
  endtask

  task automatic test_backpressure();
    int n;
    int acc;
    do_reset();
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    tick;
    wgt_ready = 1'b1; ifm_ready = 1'b1;
    tick;
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    n = 0;
    while (compute_en === 1'b1 && n < 100) begin
      tick; n++;
    end
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      out_ready = ((i % 3) == 0);
      #1;
      n_checks++;
      if (drain_en !== out_ready || f_tile !== 4'd0 || p_tile !== 4'd0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_drain cycle %0d: drain_en=%b out_ready=%b idx=(%0d,%0d) busy=%b required mirror (0,0) 1",
                 i, drain_en, out_ready, f_tile, p_tile, busy);
      end
      if (out_ready) acc++;
      if (acc == 16) break;
      tick;
    end
    tick;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (acc != 16 || drain_en !== 1'b0 || p_tile !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rows: accepted=%0d drain_en=%b p_tile=%0d required 16 0 0", acc, drain_en, p_tile);
    end
    tick;
    n_checks++;
    if (wgt_load !== 1'b1 || p_tile !== 4'd1 || ifm_size !== 5'd4 || wgt_size !== 5'd16) begin
      n_fail++;
      $display("FAIL bp_next_load: load=%b p_tile=%0d sizes=(%0d,%0d) required 1 1 (16,4)", wgt_load, p_tile, wgt_size, ifm_size);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d0;
    int n;
    logic [24:0] outs;
    do_reset();
    start = 1'b1; tick; start = 1'b0;
    finish_tile();
    finish_tile();
    wgt_ready = 1'b1; ifm_ready = 1'b1;
    n = 0;
    while (compute_en !== 1'b1 && n < 20) begin
      tick; n++;
    end
    wgt_ready = 1'b0; ifm_ready = 1'b0;
    for (int c = 0; c < 10; c++) tick;
    n_checks++;
    if (compute_en !== 1'b1 || f_tile !== 4'd1 || p_tile !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_pre: compute_en=%b idx=(%0d,%0d) required 1 (1,0)", compute_en, f_tile, p_tile);
    end
    d0 = done_cnt;
    rst_n = 1'b1;
    tick;
    outs = {busy, done, wgt_load, ifm_load, acc_clr, compute_en, drain_en,
            wgt_size, ifm_size, f_tile, p_tile};
    n_checks++;
    if (outs !== 25'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h required 0", outs);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    n_checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL mid_no_done: busy=%b extra done=%0d required 0 0", busy, done_cnt - d0);
    end
    start = 1'b1; tick; start = 1'b0;
    n_checks++;
    if (wgt_load !== 1'b1 || f_tile !== 4'd0 || p_tile !== 4'd0 || wgt_size !== 5'd16 || ifm_size !== 5'd16) begin
      n_fail++;
      $display("FAIL mid_restart: load=%b idx=(%0d,%0d) sizes=(%0d,%0d) required 1 (0,0) (16,16)",
               wgt_load, f_tile, p_tile, wgt_size, ifm_size);
    end
  endtask

  task automatic test_start_held();
    int loads;
    int n;
    int d0;
    do_reset();
    d0 = done_cnt;
    start = 1'b1;
    tick;
    loads = 0;
    n = 0;
    wgt_ready = 1'b1; ifm_ready = 1'b1; out_ready = 1'b1;
    while (done !== 1'b1 && n < 1000) begin
      if (wgt_load === 1'b1) loads++;
      tick; n++;
    end
    n_checks++;
    if (loads != 4 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL held_loads: loads=%0d done=%b required 4 1", loads, done);
    end
    tick;
    n_checks++;
    if (busy !== 1'b0 || wgt_load !== 1'b0 || (done_cnt - d0) != 1) begin
      n_fail++;
      $display("FAIL held_idle: busy=%b load=%b pulses=%0d required 0 0 1", busy, wgt_load, done_cnt - d0);
    end
    tick;
    n_checks++;
    if (wgt_load !== 1'b1 || busy !== 1'b1 || f_tile !== 4'd0 || p_tile !== 4'd0) begin
      n_fail++;
      $display("FAIL held_restart: load=%b busy=%b idx=(%0d,%0d) required 1 1 (0,0)", wgt_load, busy, f_tile, p_tile);
    end
    start = 1'b0; wgt_ready = 1'b0; ifm_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; wgt_ready = 1'b0; ifm_ready = 1'b0; out_ready = 1'b0;
    test_reset();
    test_full_layer();
    test_ready_order();
    test_backpressure();
    test_reset_mid();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
